// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron datapath: default widths, decoder FSM states
// and the saturation helper.
package lif_pkg;

  localparam int unsigned DefWindowW = 10;
  localparam int unsigned DefCntW    = 8;
  localparam int unsigned DefIsiW    = 8;

  typedef enum logic [0:0] {
    StIdle,
    StCount
  } state_e;

  // All-ones value of a w-bit counter.
  function automatic int unsigned sat_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous load and clear; load has priority over clear,
// and clear has priority over increment.
module sat_counter
  import lif_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] Max = W'(sat_max(W));

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != Max)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-to-value decoder: counts spikes per programmable window, tracks the latest
// inter-spike interval and offers {rate, isi} through a one-entry valid/ready register.
module spike_rate_decoder
  import lif_pkg::*;
#(
  parameter int unsigned WINDOW_W = DefWindowW,
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned ISI_W    = DefIsiW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                spike_in,
  input  logic [WINDOW_W-1:0] window_len,
  output logic [CNT_W-1:0]    rate_out,
  output logic [ISI_W-1:0]    isi_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(sat_max(CNT_W));

  state_e              state_q, state_d;
  logic [WINDOW_W-1:0] win_ctr_q, win_ctr_d, win_len_eff;
  logic                win_start, win_end;

  logic [CNT_W-1:0]    spike_cnt, rate_final;
  logic [ISI_W-1:0]    isi_ctr, isi_final;
  logic [ISI_W-1:0]    isi_last_q, isi_last_d;
  logic                seen_q, seen_d, isi_spike;

  logic [CNT_W-1:0]    rate_q, rate_d;
  logic [ISI_W-1:0]    isi_q, isi_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;

  assign win_len_eff = (window_len == '0) ? WINDOW_W'(1) : window_len;

  // Window FSM; a finishing window restarts immediately with a fresh length.
  always_comb begin
    state_d   = state_q;
    win_ctr_d = win_ctr_q;
    win_start = 1'b0;
    win_end   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d   = StCount;
          win_start = 1'b1;
          win_ctr_d = win_len_eff;
        end
      end
      StCount: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (win_ctr_q == WINDOW_W'(1)) begin
          win_end   = 1'b1;
          win_start = 1'b1;
          win_ctr_d = win_len_eff;
        end else begin
          win_ctr_d = win_ctr_q - WINDOW_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  sat_counter #(
    .W(CNT_W)
  ) u_spike_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (win_start),
    .load     (1'b0),
    .load_val ('0),
    .inc      ((state_q == StCount) && spike_in),
    .count    (spike_cnt)
  );

  sat_counter #(
    .W(ISI_W)
  ) u_isi_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (!enable),
    .load     (enable && spike_in),
    .load_val (ISI_W'(1)),
    .inc      (enable && seen_q),
    .count    (isi_ctr)
  );

  // Results include the spike of the last window cycle itself.
  assign rate_final = (spike_in && (spike_cnt != CntMax)) ? spike_cnt + CNT_W'(1) : spike_cnt;
  assign isi_spike  = enable && spike_in && seen_q;
  assign isi_final  = isi_spike ? isi_ctr : isi_last_q;

  always_comb begin
    isi_last_d = enable ? isi_final : '0;
    seen_d     = enable && (seen_q || spike_in);
  end

  always_comb begin
    valid_d = valid_q;
    rate_d  = rate_q;
    isi_d   = isi_q;
    ovr_d   = ovr_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (win_end) begin
      if (!valid_q || out_ready) begin
        valid_d = 1'b1;
        rate_d  = rate_final;
        isi_d   = isi_final;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (!enable) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      win_ctr_q  <= '0;
      isi_last_q <= '0;
      seen_q     <= 1'b0;
      rate_q     <= '0;
      isi_q      <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_ctr_q  <= win_ctr_d;
      isi_last_q <= isi_last_d;
      seen_q     <= seen_d;
      rate_q     <= rate_d;
      isi_q      <= isi_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rate_out  = rate_q;
  assign isi_out   = isi_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;

endmodule
